biu_arbiter: RTL and testbench
==============================

# biu_arbiter

Two-master arbiter in front of the SDRAM bus interface unit (BIU). Grants exactly one master at a time, steers that master's Control/AddrIn/DataIn onto the BIU and returns Ready only to it. Holds a grant for a whole multi-transaction tenure. Rotates priority round-robin and waits for the BIU to drain back to idle before switching owners.

## Interface
- HOLD_MAX, default 64: tenure cycle limit used by the hold-limit feature (8-bit counter, 1..255).
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Req0, Req1  in  1  master request; held high for the whole tenure.
- Control0, Control1  in  9  master control: [8:7] state (00 START, 01 CONT, 10 IDLE, 11 BUSY), [6:3] burst, [2:1] size, [0] write.
- Addr0, Addr1  in  32  master address.
- Data0, Data1  in  32  master write data.
- Gnt0, Gnt1  out  1  registered grant; never both high.
- Ready0, Ready1  out  1  BiuReady gated by own grant.
- Yield0, Yield1  out  1  tenure limit reached and other master waiting (hold-limit feature only).
- BiuControl  out  9  control to BIU.
- BiuAddr  out  32  address to BIU.
- BiuData  out  32  data to BIU.
- BiuEn  out  1  BIU enable; high only while a grant is held.
- BiuReady  in  1  Ready from BIU.

## Operation
- FSM states: IDLE, OWN0, OWN1, DRAIN. Round-robin pointer Last (1 bit) = last served master.
- IDLE:
  - One request pending: go to OWN of that master.
  - Both pending: grant master !Last.
  - Set Gnt on the transition; Last updates to the granted master.
- OWNi:
  - Mux master i's Control/Addr/Data to BIU; BiuEn=1; Ready_i=BiuReady; other Ready=0.
  - Req_i low: go to DRAIN; Gnt_i drops on the same edge.
- DRAIN:
  - Drive BiuControl=9'b10_0000_000 (IDLE), BiuAddr=0, BiuData=0, BiuEn=1.
  - When BiuReady=1: go to IDLE.
  - Guarantees the BIU finished its precharge/burst before the next master drives it.
- No grant (IDLE/reset): BiuControl=9'b10_0000_000, BiuAddr=0, BiuData=0, BiuEn=0, Ready0=Ready1=0.
- Output muxing is combinational from the registered state; no input registering.
- Reset values: state IDLE, Last=1 (master 0 wins first tie), Gnt0=Gnt1=0, Yield0=Yield1=0, tenure counter 0.
- Reset mid-tenure: grant removed immediately (async); BIU sees IDLE control and BiuEn=0 from that point.
- Req_i drop coincident with a new request from the other master: DRAIN first, then IDLE, then grant. The other master is never granted directly from OWN.
- Requests in DRAIN are held pending, not lost.
- Control[8:7]=11 (BUSY) from the owner passes through unchanged; the arbiter does not interpret it.

## Timing
- Grant latency: Req_i sampled high in IDLE at edge k -> Gnt_i high after edge k; BIU sees master i's Control in the same cycle.
- Release: Req_i low at edge k -> DRAIN from edge k. Minimum 1 DRAIN cycle (exit on first edge with BiuReady=1), then 1 IDLE cycle.
- Minimum owner-to-owner gap: 2 cycles (DRAIN, IDLE).
- Ready_i is combinational: BiuReady & Gnt_i, zero extra latency.

## Configuration
- BIU_ARB_HOLD_LIMIT_EN defined:
  - 8-bit tenure counter clears on entry to OWNi, increments each OWNi cycle, saturates at HOLD_MAX.
  - Yield_i = (counter==HOLD_MAX) & Req_(other) & Gnt_i.
  - The owner is expected to drop Req at its next START boundary. The arbiter does not revoke Gnt itself.
- BIU_ARB_HOLD_LIMIT_EN undefined:
  - No counter; Yield0=Yield1=0 constant.
  - Tenure is unbounded.

## Test plan
- Reset: Rst=0 with Req0=Req1=1 -> Gnt0=Gnt1=0, BiuEn=0, BiuControl=9'h100. Release Rst -> Gnt0=1 after the first edge.
- Single master: Req1=1, Control1=9'h009, Addr1=32'h0000_0040 -> Gnt1=1 next cycle; BiuControl=9'h009, BiuAddr=32'h40; Ready1 follows BiuReady; Ready0=0.
- Tie and rotation: both Req high from IDLE -> Gnt0. Drop Req0 with BiuReady=1 -> DRAIN 1 cycle, IDLE 1 cycle, then Gnt1.
- Drain wait: owner drops Req while BiuReady=0 for 5 cycles -> DRAIN held 5 cycles with BiuControl=9'h100; next grant 2 cycles after BiuReady rises.
- Async reset mid-burst: Rst low in OWN0 -> Gnt0=0 and BiuEn=0 immediately. After release, Last=1 so master 0 regains priority on a tie.
- Hold limit (macro defined, HOLD_MAX=4): Req0 held, Req1 raised -> Yield0=1 after the 4th OWN0 cycle. Yield0 stays 0 with the macro undefined.

Source files
------------

// File: rtl/biu_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM BIU.
// Define BIU_ARB_HOLD_LIMIT_EN to enable the tenure counter and Yield outputs.
module biu_arbiter #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [8:0]  Control0,
  input  logic [8:0]  Control1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] Data0,
  input  logic [31:0] Data1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Ready0,
  output logic        Ready1,
  output logic        Yield0,
  output logic        Yield1,
  output logic [8:0]  BiuControl,
  output logic [31:0] BiuAddr,
  output logic [31:0] BiuData,
  output logic        BiuEn,
  input  logic        BiuReady
);

  typedef enum logic [1:0] {
    IDLE, OWN0, OWN1, DRAIN
  } state_t;

  localparam logic [8:0] CTRL_IDLE = 9'b10_0000_000;

  state_t state, state_nx;
  logic   last, last_nx;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 1..255");
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (Req0 && (!Req1 || last)) begin
          state_nx = OWN0;
          last_nx  = 1'b0;
        end else if (Req1) begin
          state_nx = OWN1;
          last_nx  = 1'b1;
        end
      end
      OWN0:  if (!Req0) state_nx = DRAIN;
      OWN1:  if (!Req1) state_nx = DRAIN;
      DRAIN: if (BiuReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Gnt0   = (state == OWN0);
  assign Gnt1   = (state == OWN1);
  assign Ready0 = BiuReady & Gnt0;
  assign Ready1 = BiuReady & Gnt1;

  always_comb begin
    BiuControl = CTRL_IDLE;
    BiuAddr    = '0;
    BiuData    = '0;
    BiuEn      = 1'b0;
    unique case (1'b1)
      Gnt0: begin
        BiuControl = Control0;
        BiuAddr    = Addr0;
        BiuData    = Data0;
        BiuEn      = 1'b1;
      end
      Gnt1: begin
        BiuControl = Control1;
        BiuAddr    = Addr1;
        BiuData    = Data1;
        BiuEn      = 1'b1;
      end
      (state == DRAIN): BiuEn = 1'b1;
      default: ;
    endcase
  end

`ifdef BIU_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HMAX = 8'(HOLD_MAX);

  logic [7:0] tenure;

  // Every tenure is entered from IDLE, so clearing there clears on entry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tenure <= '0;
    end else if (state == IDLE) begin
      tenure <= '0;
    end else if ((Gnt0 || Gnt1) && tenure != HMAX) begin
      tenure <= tenure + 8'd1;
    end
  end

  assign Yield0 = Gnt0 & Req1 & (tenure == HMAX);
  assign Yield1 = Gnt1 & Req0 & (tenure == HMAX);
`else
  assign Yield0 = 1'b0;
  assign Yield1 = 1'b0;
`endif

endmodule

// File: tb/tb_biu_arbiter.sv
// Scoreboard bench for biu_arbiter: a reference model predicts each cycle's
// outputs, a negedge monitor pops and compares them.
module tb_biu_arbiter;

  localparam int HOLD_MAX = 4;

  logic        Clk = 1'b0;
  logic        Rst, Req0, Req1, BiuReady;
  logic [8:0]  Control0, Control1;
  logic [31:0] Addr0, Addr1, Data0, Data1;
  logic        Gnt0, Gnt1, Ready0, Ready1, Yield0, Yield1, BiuEn;
  logic [8:0]  BiuControl;
  logic [31:0] BiuAddr, BiuData;

  biu_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .Control0(Control0), .Control1(Control1),
    .Addr0(Addr0), .Addr1(Addr1), .Data0(Data0), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Ready0(Ready0), .Ready1(Ready1),
    .Yield0(Yield0), .Yield1(Yield1),
    .BiuControl(BiuControl), .BiuAddr(BiuAddr), .BiuData(BiuData),
    .BiuEn(BiuEn), .BiuReady(BiuReady)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        gnt0, gnt1, rdy0, rdy1, y0, y1, en;
    logic [8:0]  ctrl;
    logic [31:0] addr, data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference: who owns the bus (-1 none), draining, last served, tenure
  int owner = -1;
  bit drain = 0;
  bit last  = 1;
  int ten   = 0;

  function automatic void model_reset();
    owner = -1; drain = 0; last = 1; ten = 0;
  endfunction

  function automatic void model_edge();
    bit req_own;
    if (!Rst) begin
      model_reset();
    end else if (drain) begin
      if (BiuReady) drain = 0;
    end else if (owner >= 0) begin
      req_own = (owner == 0) ? Req0 : Req1;
      if (!req_own) begin
        owner = -1;
        drain = 1;
      end else if (ten < HOLD_MAX) begin
        ten++;
      end
    end else if (Req0 || Req1) begin
      if (Req0 && Req1) owner = last ? 0 : 1;
      else owner = Req0 ? 0 : 1;
      last = (owner == 1);
      ten  = 0;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.gnt0 = (owner == 0);
    e.gnt1 = (owner == 1);
    e.rdy0 = e.gnt0 && BiuReady;
    e.rdy1 = e.gnt1 && BiuReady;
`ifdef BIU_ARB_HOLD_LIMIT_EN
    e.y0 = e.gnt0 && Req1 && ten == HOLD_MAX;
    e.y1 = e.gnt1 && Req0 && ten == HOLD_MAX;
`else
    e.y0 = 1'b0;
    e.y1 = 1'b0;
`endif
    e.en   = (owner >= 0) || drain;
    e.ctrl = (owner == 0) ? Control0 : (owner == 1) ? Control1 : 9'h100;
    e.addr = (owner == 0) ? Addr0 : (owner == 1) ? Addr1 : 32'h0;
    e.data = (owner == 0) ? Data0 : (owner == 1) ? Data1 : 32'h0;
    return e;
  endfunction

  task automatic step(input logic r, q0, q1, br,
                      input logic [8:0] c0, c1,
                      input logic [31:0] a0, a1, d0, d1);
    @(posedge Clk);
    model_edge();
    #1;
    Rst = r; Req0 = q0; Req1 = q1; BiuReady = br;
    Control0 = c0; Control1 = c1;
    Addr0 = a0; Addr1 = a1; Data0 = d0; Data1 = d1;
    if (!r) model_reset();
    cyc++;
    q.push_back(predict());
  endtask

  task automatic simple(input logic r, q0, q1, br);
    step(r, q0, q1, br, 9'h0A5, 9'h009,
         32'h0000_1000, 32'h0000_0040, 32'hAAAA_0000, 32'h5555_0001);
  endtask

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt0", 32'(Gnt0), 32'(e.gnt0));
      chk("gnt1", 32'(Gnt1), 32'(e.gnt1));
      chk("ready0", 32'(Ready0), 32'(e.rdy0));
      chk("ready1", 32'(Ready1), 32'(e.rdy1));
      chk("yield0", 32'(Yield0), 32'(e.y0));
      chk("yield1", 32'(Yield1), 32'(e.y1));
      chk("biu_en", 32'(BiuEn), 32'(e.en));
      chk("biu_ctrl", 32'(BiuControl), 32'(e.ctrl));
      chk("biu_addr", BiuAddr, e.addr);
      chk("biu_data", BiuData, e.data);
    end
  end

  initial begin
    logic rq0, rq1;
    Rst = 0; Req0 = 1; Req1 = 1; BiuReady = 0;
    Control0 = 0; Control1 = 0; Addr0 = 0; Addr1 = 0; Data0 = 0; Data1 = 0;

    // reset held with both requesting, then release: master 0 wins tie
    simple(0, 1, 1, 0);
    simple(0, 1, 1, 0);
    simple(1, 1, 1, 1);
    simple(1, 1, 1, 1);
    simple(1, 1, 1, 0);
    // drop Req0 with BiuReady=1: DRAIN, IDLE, then Gnt1
    simple(1, 0, 1, 1);
    simple(1, 0, 1, 1);
    simple(1, 0, 1, 1);
    simple(1, 0, 1, 0);
    // owner drops with BiuReady low for 5 cycles
    simple(1, 0, 0, 0);
    repeat (4) simple(1, 1, 0, 0);
    simple(1, 1, 0, 1);
    repeat (3) simple(1, 1, 0, 1);
    // async reset mid-tenure, then tie goes to master 0 again
    simple(0, 1, 1, 1);
    simple(1, 1, 1, 1);
    repeat (2) simple(1, 1, 1, 0);
    simple(1, 0, 0, 1);
    repeat (2) simple(1, 0, 0, 1);
    // single master 1, then hold-limit with master 0 held and 1 waiting
    repeat (3) simple(1, 0, 1, 1);
    simple(1, 0, 0, 1);
    repeat (2) simple(1, 1, 0, 1);
    repeat (8) simple(1, 1, 1, 0);
    simple(1, 0, 1, 1);

    rq0 = 0; rq1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rq0 = ~rq0;
      if ($urandom_range(7) == 0) rq1 = ~rq1;
      step(($urandom_range(199) != 0), rq0, rq1, 1'($urandom),
           9'($urandom), 9'($urandom),
           $urandom, $urandom, $urandom, $urandom);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge Clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
